dev_bus_arbiter: RTL and testbench

DEV_BUS_ARBITER -- requirements
Module: dev_bus_arbiter

---
 rtl/dev_bus_arbiter_pkg.sv | 16 +
 rtl/dev_bus_arbiter_rr_pick.sv | 21 ++
 rtl/dev_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_dev_bus_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-master device bus: arbiter state encoding,
// default burst limit and the word-aligned base addresses of the devices.
package dev_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } bus_state_e;

    localparam int MAX_BURST_DEFAULT = 4;

    localparam logic [31:0] COUNTER_BASE = 32'h0000_7F00;
    localparam logic [31:0] SCREEN_BASE  = 32'h0000_8000;

endpackage

// File: rtl/dev_bus_arbiter_rr_pick.sv
// Two-way round-robin selector: a sole requester wins, and on contention the
// master that did not own the bus last wins.
module dev_bus_arbiter_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       valid
);

    // Pick the winner from the current request pair and the last owner
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        unique case (req)
            2'b11:   winner = ~last_owner;
            2'b10:   winner = 1'b1;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Arbiter sharing one device bridge between two masters. Each ack commits
// exactly one access at the next rising edge; a locked owner may keep the bus
// for up to MAX_BURST consecutive accesses before it must yield to a waiting
// master. Handshake: mx_req is the master's valid, mx_ack is the arbiter's
// ready; an access happens on a rising edge where both are high, and the
// master holds addr/wd/we/lock stable until it has seen that edge.
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic [29:0] PrAddr,
    output logic [31:0] PrWD,
    output logic        WeCPU,
    input  logic [31:0] PrRD,
    output logic        busy,
    output logic        owner,
    output bus_state_e  state
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    bus_state_e    state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          last_owner_q;

    logic       cur;
    logic       cur_req;
    logic       cur_lock;
    logic       oth_req;
    logic       owning;
    logic       acked;
    logic       pick_winner;
    logic       pick_valid;
    bus_state_e pick_state;

    assign owning   = (state_q != IDLE);
    assign cur      = (state_q == OWN1);
    assign cur_req  = cur ? m1_req  : m0_req;
    assign cur_lock = cur ? m1_lock : m0_lock;
    assign oth_req  = cur ? m0_req  : m1_req;
    assign acked    = owning & cur_req;

    dev_bus_arbiter_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    assign pick_state = !pick_valid ? IDLE : (pick_winner ? OWN1 : OWN0);

    // State register, burst counter and last owner; reset parks the bus idle
    // with m0 favoured at the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            if (acked) begin
                last_owner_q <= cur;
            end
        end
    end

    // Next state: arbitrate from idle or after a withdrawal, extend a locked
    // burst while under the limit, otherwise yield to a waiting master
    always_comb begin
        state_d = state_q;
        burst_d = '0;
        case (state_q)
            IDLE: begin
                state_d = pick_state;
            end
            OWN0, OWN1: begin
                if (!cur_req) begin
                    state_d = pick_state;
                end else if (cur_lock && (burst_q < BURST_LAST)) begin
                    state_d = state_q;
                    burst_d = burst_q + 1'b1;
                end else if (oth_req) begin
                    state_d = cur ? OWN0 : OWN1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the owner's request drives the bridge only while it is asserted
    always_comb begin
        PrAddr = '0;
        PrWD   = '0;
        WeCPU  = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        m0_rd  = '0;
        m1_rd  = '0;
        busy   = owning;
        owner  = cur;
        state  = state_q;
        if (acked) begin
            PrAddr = cur ? m1_addr : m0_addr;
            PrWD   = cur ? m1_wd   : m0_wd;
            WeCPU  = cur ? m1_we   : m0_we;
            if (cur) begin
                m1_ack = 1'b1;
                m1_rd  = PrRD;
            end else begin
                m0_ack = 1'b1;
                m0_rd  = PrRD;
            end
        end
    end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: master driver tasks, a bridge read
// model, and a scoreboard of expected committed accesses in commit order.
module tb_dev_bus_arbiter;
    import dev_bus_arbiter_pkg::*;

    localparam int W  = 66;
    localparam int MB = 4;
    localparam logic [29:0] CNT_WA = COUNTER_BASE[31:2];
    localparam logic [29:0] SCR_WA = SCREEN_BASE[31:2];

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_lock, m0_we, m0_ack;
    logic [29:0] m0_addr;
    logic [31:0] m0_wd, m0_rd;
    logic        m1_req, m1_lock, m1_we, m1_ack;
    logic [29:0] m1_addr;
    logic [31:0] m1_wd, m1_rd;
    logic [29:0] PrAddr;
    logic [31:0] PrWD, PrRD;
    logic        WeCPU, busy, owner;
    bus_state_e  state;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic [1:0]   ack_seen = 2'b00;

    dev_bus_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_we(m0_we), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_we(m1_we), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .PrAddr(PrAddr), .PrWD(PrWD), .WeCPU(WeCPU), .PrRD(PrRD),
        .busy(busy), .owner(owner), .state(state)
    );

    // Bridge read model: the screen word returns a fixed pattern
    function automatic logic [31:0] rd_model(input logic [29:0] a);
        if (a == SCR_WA) return 32'h1234_5678;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign PrRD = rd_model(PrAddr);

    function automatic logic [W-1:0] mk_exp(input bit m, input bit we,
                                            input logic [29:0] a, input logic [31:0] d);
        return {1'b1, m, m, we, a, (we ? d : rd_model(a))};
    endfunction

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [W-1:0] obs, e;
        logic [31:0]  other_rd;
        ack_seen = {m1_ack, m0_ack};
        n_cmp++;
        if (m0_ack && m1_ack) begin
            n_bad++;
            $display("FAIL dual_ack t=%0t: both acks high, required at most one", $time);
        end else if (m0_ack || m1_ack) begin
            obs = {busy, m1_ack, owner, WeCPU, PrAddr,
                   (WeCPU ? PrWD : (m1_ack ? m1_rd : m0_rd))};
            other_rd = m1_ack ? m0_rd : m1_rd;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack t=%0t: got %h, required no access", $time, obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e || other_rd !== 32'h0) begin
                    n_bad++;
                    $display("FAIL access t=%0t: got %h other_rd=%h, required %h other_rd=0",
                             $time, obs, other_rd, e);
                end
            end
        end else begin
            if (WeCPU !== 1'b0 || m0_rd !== 32'h0 || m1_rd !== 32'h0 ||
                (state == IDLE && {PrAddr, PrWD, busy, owner} !== '0)) begin
                n_bad++;
                $display("FAIL quiet_bus t=%0t: we=%b rd0=%h rd1=%h addr=%h wd=%h busy=%b, required all 0",
                         $time, WeCPU, m0_rd, m1_rd, PrAddr, PrWD, busy);
            end
        end
    end

    // Driver tasks
    task automatic set_master(input bit m, input bit req, input bit lock, input bit we,
                              input logic [29:0] a, input logic [31:0] d);
        if (m) begin
            m1_req = req; m1_lock = lock; m1_we = we; m1_addr = a; m1_wd = d;
        end else begin
            m0_req = req; m0_lock = lock; m0_we = we; m0_addr = a; m0_wd = d;
        end
    endtask

    task automatic release_master(input bit m);
        set_master(m, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    endtask

    // Hold one access until an edge commits it; returns 1 time unit after that edge
    task automatic drive_access(input bit m, input bit we, input logic [29:0] a,
                                input logic [31:0] d, input bit lock);
        bit done;
        done = 1'b0;
        set_master(m, 1'b1, lock, we, a, d);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            done = ack_seen[m];
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL access_timeout m%0d addr=%h: no ack, required ack within 40 cycles", m, a);
        end
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (state == IDLE);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_idle: state=%0d, required IDLE(0)", name, state);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending: %0d expected accesses left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Tests
    task automatic test_reset();
        m0_req = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (state !== IDLE || m0_ack !== 1'b0 || busy !== 1'b0 || WeCPU !== 1'b0 ||
            PrAddr !== 30'h0 || owner !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: state=%0d ack0=%b busy=%b we=%b addr=%h, required all 0",
                     state, m0_ack, busy, WeCPU, PrAddr);
        end
        m0_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #2;
        n_cmp++;
        if (state !== IDLE) begin
            n_bad++;
            $display("FAIL reset_release: state=%0d, required IDLE(0)", state);
        end
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        exp_q.push_back(mk_exp(1'b0, 1'b0, CNT_WA + 30'd4, 32'h0));
        exp_q.push_back(mk_exp(1'b1, 1'b0, CNT_WA + 30'd5, 32'h0));
        fork
            begin drive_access(1'b0, 1'b0, CNT_WA + 30'd4, 32'h0, 1'b0); release_master(1'b0); end
            begin drive_access(1'b1, 1'b0, CNT_WA + 30'd5, 32'h0, 1'b0); release_master(1'b1); end
        join
        wait_idle("contention");
        check_drained("contention");
    endtask

    task automatic test_single_write();
        @(posedge clk); #1;
        set_master(1'b0, 1'b1, 1'b0, 1'b1, CNT_WA, 32'h0000_000A);
        exp_q.push_back(mk_exp(1'b0, 1'b1, CNT_WA, 32'h0000_000A));
        #2;
        n_cmp++;
        if (state !== IDLE || m0_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL write_latency: state=%0d ack0=%b before edge, required IDLE and 0", state, m0_ack);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (state !== OWN0 || m0_ack !== 1'b1 || WeCPU !== 1'b1 ||
            PrWD !== 32'h0000_000A || PrAddr !== CNT_WA) begin
            n_bad++;
            $display("FAIL write_cycle: state=%0d ack0=%b we=%b wd=%h addr=%h, required 1/1/1/0000000a/%h",
                     state, m0_ack, WeCPU, PrWD, PrAddr, CNT_WA);
        end
        @(posedge clk); #1;
        release_master(1'b0);
        #1;
        n_cmp++;
        if (m0_ack !== 1'b0 || WeCPU !== 1'b0) begin
            n_bad++;
            $display("FAIL write_after: ack0=%b we=%b, required 0/0", m0_ack, WeCPU);
        end
        wait_idle("single_write");
        check_drained("single_write");
    endtask

    task automatic test_back_to_back();
        int start;
        @(posedge clk); #1;
        start = cyc;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk_exp(1'b0, 1'b0, CNT_WA + 30'(i + 8), 32'h0));
        for (int i = 0; i < 3; i++)
            drive_access(1'b0, 1'b0, CNT_WA + 30'(i + 8), 32'h0, 1'b0);
        release_master(1'b0);
        n_cmp++;
        if (cyc - start != 4) begin
            n_bad++;
            $display("FAIL back_to_back_cycles: took %0d edges, required 4", cyc - start);
        end
        wait_idle("back_to_back");
        check_drained("back_to_back");
    endtask

    task automatic test_burst_lock();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_exp(1'b1, 1'b0, CNT_WA + 30'(i + 16), 32'h0));
        exp_q.push_back(mk_exp(1'b0, 1'b0, CNT_WA + 30'd32, 32'h0));
        for (int i = 4; i < 6; i++)
            exp_q.push_back(mk_exp(1'b1, 1'b0, CNT_WA + 30'(i + 16), 32'h0));
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive_access(1'b1, 1'b0, CNT_WA + 30'(i + 16), 32'h0, 1'b1);
                release_master(1'b1);
            end
            begin
                @(posedge clk); #1;
                drive_access(1'b0, 1'b0, CNT_WA + 30'd32, 32'h0, 1'b0);
                release_master(1'b0);
            end
        join
        wait_idle("burst_lock");
        check_drained("burst_lock");
    endtask

    task automatic test_screen_read();
        @(posedge clk); #1;
        exp_q.push_back(mk_exp(1'b1, 1'b0, SCR_WA, 32'h0));
        drive_access(1'b1, 1'b0, SCR_WA, 32'h0, 1'b0);
        release_master(1'b1);
        wait_idle("screen_read");
        check_drained("screen_read");
    endtask

    task automatic test_reset_mid_write();
        @(posedge clk); #1;
        set_master(1'b0, 1'b1, 1'b0, 1'b1, CNT_WA, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        n_cmp++;
        if (WeCPU !== 1'b1 || state !== OWN0) begin
            n_bad++;
            $display("FAIL rst_pre_write: we=%b state=%0d, required 1/OWN0(1)", WeCPU, state);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (WeCPU !== 1'b0 || m0_ack !== 1'b0 || state !== IDLE) begin
            n_bad++;
            $display("FAIL rst_mid_write: we=%b ack0=%b state=%0d, required 0/0/IDLE(0)",
                     WeCPU, m0_ack, state);
        end
        release_master(1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_master(1'b1, 1'b1, 1'b0, 1'b0, CNT_WA + 30'd3, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, CNT_WA + 30'd3, 32'h0));
        @(posedge clk); #2;
        n_cmp++;
        if (m1_ack !== 1'b1 || state !== OWN1) begin
            n_bad++;
            $display("FAIL rst_fresh_grant: ack1=%b state=%0d, required 1/OWN1(2)", m1_ack, state);
        end
        @(posedge clk); #1;
        release_master(1'b1);
        wait_idle("reset_mid_write");
        check_drained("reset_mid_write");
    endtask

    task automatic test_withdraw();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        set_master(1'b0, 1'b1, 1'b0, 1'b1, CNT_WA, 32'h5555_AAAA);
        set_master(1'b1, 1'b1, 1'b0, 1'b0, CNT_WA + 30'd7, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, CNT_WA + 30'd7, 32'h0));
        @(posedge clk); #1;
        m0_req = 1'b0;
        #1;
        n_cmp++;
        if (state !== OWN0 || m0_ack !== 1'b0 || WeCPU !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL withdraw_cycle: state=%0d ack0=%b we=%b busy=%b, required OWN0(1)/0/0/1",
                     state, m0_ack, WeCPU, busy);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (state !== OWN1 || m1_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL withdraw_handover: state=%0d ack1=%b, required OWN1(2)/1", state, m1_ack);
        end
        @(posedge clk); #1;
        release_master(1'b0);
        release_master(1'b1);
        wait_idle("withdraw");
        check_drained("withdraw");
    endtask

    task automatic test_random_singles();
        bit          m, we;
        logic [29:0] a;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            m  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = 30'($urandom());
            d  = $urandom();
            exp_q.push_back(mk_exp(m, we, a, d));
            drive_access(m, we, a, d, 1'b0);
            release_master(m);
            wait_idle("random");
        end
        check_drained("random");
    endtask

    // Test sequence and final report
    initial begin
        rst_n = 1'b0;
        release_master(1'b0);
        release_master(1'b1);
        test_reset();
        test_contention();
        test_single_write();
        test_back_to_back();
        test_burst_lock();
        test_screen_read();
        test_reset_mid_write();
        test_withdraw();
        test_random_singles();
        check_drained("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
